// File: rtl/cf_math_pkg.sv
// Shared types for the runtime ceil/floor division and ceil-log2 unit.
package cf_math_pkg;

   typedef enum logic [1:0] {
      OP_CEIL_DIV  = 2'd0,
      OP_FLOOR_DIV = 2'd1,
      OP_CLOG2     = 2'd2,
      OP_RSVD      = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/cf_math_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module cf_math_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_q
);

   logic [WIDTH+1:0] w_trial;
   logic [WIDTH+1:0] w_diff;

   // Two guard bits: the trial value can reach 2*div-1, so bit WIDTH+1 is a clean borrow flag.
   assign w_trial = {1'b0, i_rem, i_bit};
   assign w_diff  = w_trial - {2'b00, i_div};
   assign o_q     = ~w_diff[WIDTH+1];
   assign o_rem   = o_q ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

endmodule

// File: rtl/cf_math_seq_unit.sv
// Multi-cycle ceil/floor division and ceil(log2) with valid/ready on both sides.
// Input handshake: in_valid_i & in_ready_o; output handshake: out_valid_o & out_ready_i.
module cf_math_seq_unit
   import cf_math_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             err_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e             r_state;
   op_e                r_op;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_result;
   logic               r_err;
   logic [CNT_W-1:0]   r_cnt;

   op_e                w_op_in;
   logic [WIDTH-1:0]   w_rem_next;
   logic               w_q_bit;
   logic [WIDTH-1:0]   w_quo_next;
   logic               w_last;
   logic               w_round_up;

   assign w_op_in    = op_e'(op_i);
   assign w_quo_next = {r_quo[WIDTH-2:0], w_q_bit};
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_round_up = (r_op == OP_CEIL_DIV) && (w_rem_next != '0);

   // r_quo doubles as the dividend shift register: its MSB feeds the step, the new quotient bit enters at the LSB.
   cf_math_div_step #(.WIDTH(WIDTH)) u_div_step (
      .i_rem (r_rem),
      .i_bit (r_quo[WIDTH-1]),
      .i_div (r_b),
      .o_rem (w_rem_next),
      .o_q   (w_q_bit)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= IDLE;
         r_op     <= OP_CEIL_DIV;
         r_rem    <= '0;
         r_quo    <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
      end else if (flush_i) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid_i) begin
                  r_op  <= w_op_in;
                  r_b   <= b_i;
                  r_quo <= a_i;
                  r_cnt <= '0;
                  r_err <= 1'b0;
                  // For CLOG2 the remainder register holds v = a-1 (0 when a==0).
                  r_rem <= (w_op_in == OP_CLOG2 && a_i != '0) ? a_i - WIDTH'(1) : '0;
                  if (w_op_in == OP_RSVD) begin
                     r_result <= '0;
                     r_err    <= 1'b1;
                     r_state  <= DONE;
                  end else if (w_op_in != OP_CLOG2 && b_i == '0) begin
                     r_result <= '1;
                     r_err    <= 1'b1;
                     r_state  <= DONE;
                  end else begin
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               if (r_op == OP_CLOG2) begin
                  if (r_rem != '0) begin
                     r_rem <= r_rem >> 1;
                     r_cnt <= r_cnt + CNT_W'(1);
                  end else begin
                     r_result <= WIDTH'(r_cnt);
                     r_state  <= DONE;
                  end
               end else begin
                  r_rem <= w_rem_next;
                  r_quo <= w_quo_next;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_last) begin
                     r_result <= w_quo_next + WIDTH'(w_round_up);
                     r_state  <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready_i) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready_o  = (r_state == IDLE);
   assign out_valid_o = (r_state == DONE);
   assign result_o    = r_result;
   assign err_o       = r_err;

endmodule
